// File: rtl/decoder_scan_sequencer.sv
// ---------------------------------------------------------------------------
// decoder_scan_sequencer
//
// Purpose:
//   Produces the select/enable pair for a one-hot decoder_nbit stage. The
//   index steps 0 .. 2**N-1. Each index is held with enable high for a
//   programmable number of cycles (the dwell). A single enable-low cycle
//   separates adjacent indices, so the decoder never shows two different
//   one-hot lines back to back. Scanning is either a single pass or
//   continuous, and a scan can be aborted at any time.
//
// Parameters:
//   N          index width; the scan covers 2**N indices
//   DWELL_W    width of the dwell input and of the internal dwell counter
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      level-sampled request to begin a scan (ignored while busy)
//   stop       abort; beats start and normal sequencing
//   continuous latched at start: 1 = wrap forever, 0 = single pass
//   dwell      enable-high cycles per index, latched at start (0 acts as 1)
//   a          registered index to the decoder
//   enable     registered enable to the decoder
//   busy       high while scanning (SCAN or BLANK)
//   done       one-cycle pulse when a single pass finishes normally
// ---------------------------------------------------------------------------
module decoder_scan_sequencer #(
    parameter int N       = 3,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [DWELL_W-1:0] dwell,
    output logic [N-1:0]       a,
    output logic               enable,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } state_t;

    localparam logic [N-1:0]       LAST_INDEX = {N{1'b1}};
    localparam logic [N-1:0]       INDEX_ONE  = N'(1);
    localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);

    state_t             state;
    state_t             state_next;

    // Scan settings captured when a start is accepted.
    logic               cont_latched;
    logic               cont_next;
    logic [DWELL_W-1:0] dwell_latched;
    logic [DWELL_W-1:0] dwell_latched_next;

    // Remaining SCAN cycles for the current index, minus one.
    logic [DWELL_W-1:0] count;
    logic [DWELL_W-1:0] count_next;

    logic [N-1:0]       a_next;
    logic               enable_next;
    logic               busy_next;
    logic               done_next;

    // A dwell of zero would otherwise mean "no enable cycles at all"; the
    // sequencer treats it as the minimum useful dwell of one cycle.
    logic [DWELL_W-1:0] dwell_effective;

    assign dwell_effective = (dwell == '0) ? DWELL_ONE : dwell;

    // Every output is a flop. The combinational block below works out what
    // each flop should hold next, so nothing here ever combines an input
    // straight onto an output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            a             <= '0;
            enable        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            count         <= '0;
            cont_latched  <= 1'b0;
            dwell_latched <= DWELL_ONE;
        end else begin
            state         <= state_next;
            a             <= a_next;
            enable        <= enable_next;
            busy          <= busy_next;
            done          <= done_next;
            count         <= count_next;
            cont_latched  <= cont_next;
            dwell_latched <= dwell_latched_next;
        end
    end

    // Next-state and next-output logic. Everything defaults to holding its
    // value, and done defaults low so it can only ever be a one-cycle pulse.
    // Stop is applied last so it overrides whatever the normal sequencing
    // chose.
    always_comb begin
        state_next         = state;
        a_next             = a;
        enable_next        = enable;
        busy_next          = busy;
        done_next          = 1'b0;
        count_next         = count;
        cont_next          = cont_latched;
        dwell_latched_next = dwell_latched;

        case (state)
            IDLE: begin
                a_next      = '0;
                enable_next = 1'b0;
                busy_next   = 1'b0;
                if (start && !stop) begin
                    cont_next          = continuous;
                    dwell_latched_next = dwell_effective;
                    count_next         = dwell_effective - DWELL_ONE;
                    state_next         = SCAN;
                    a_next             = '0;
                    enable_next        = 1'b1;
                    busy_next          = 1'b1;
                end
            end

            // Hold the index with enable high. When the counter reaches
            // zero, this is the last enable cycle for the index. The counter
            // stays at zero for the blank cycle, so it never wraps below
            // zero.
            SCAN: begin
                if (count == '0) begin
                    state_next  = BLANK;
                    enable_next = 1'b0;
                end else begin
                    count_next = count - DWELL_ONE;
                end
            end

            // One enable-low cycle. From here the index advances, wraps,
            // or the pass ends.
            BLANK: begin
                if (a != LAST_INDEX) begin
                    state_next  = SCAN;
                    a_next      = a + INDEX_ONE;
                    enable_next = 1'b1;
                    count_next  = dwell_latched - DWELL_ONE;
                end else if (cont_latched) begin
                    state_next  = SCAN;
                    a_next      = '0;
                    enable_next = 1'b1;
                    count_next  = dwell_latched - DWELL_ONE;
                end else begin
                    state_next  = IDLE;
                    a_next      = '0;
                    enable_next = 1'b0;
                    busy_next   = 1'b0;
                    done_next   = 1'b1;
                    count_next  = '0;
                end
            end

            default: begin
                state_next  = IDLE;
                a_next      = '0;
                enable_next = 1'b0;
                busy_next   = 1'b0;
                count_next  = '0;
            end
        endcase

        // An abort drops back to IDLE cleanly and raises no done.
        if (stop && (state != IDLE)) begin
            state_next  = IDLE;
            a_next      = '0;
            enable_next = 1'b0;
            busy_next   = 1'b0;
            done_next   = 1'b0;
            count_next  = '0;
        end
    end

endmodule
